// File: rtl/sequence_generator_moore.sv
// Frame serializer (MSB-first, GAP idle zeros between frames) with an overlapping Moore matcher on its own line.
// Latency 1 from accept to first bit; one-deep skid register, in_ready deasserts while it is full.
module sequence_generator_moore #(
  parameter int                 WIDTH   = 16,
  parameter int                 LEN_W   = 5,
  parameter int                 GAP     = 2,
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int                 CNT_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [LEN_W-1:0]  in_len,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              sequence_out,
  output logic              out_valid,
  output logic              frame_start,
  output logic              frame_done,
  output logic              busy,
  output logic              pattern_hit,
  output logic [CNT_W-1:0]  pattern_count
);

  localparam int MS_W = $clog2(PAT_LEN + 1);
  localparam int GC_W = 4;
  localparam logic [GC_W-1:0] GAP_M1 = (GAP > 0) ? GC_W'(GAP - 1) : '0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] shift_reg;
  logic [LEN_W-1:0] bit_cnt;
  logic             first_bit;
  logic [GC_W-1:0]  gap_cnt;
  logic [WIDTH-1:0] pend_data;
  logic [LEN_W-1:0] pend_len;
  logic             pend_full;
  logic [MS_W-1:0]  mstate;
  logic [MS_W-1:0]  mstate_nxt;
  logic [CNT_W-1:0] hit_cnt;

  logic [LEN_W-1:0] acc_len;
  logic [WIDTH-1:0] acc_data;
  logic             accept;
  logic             acc_nz;
  logic             load_pt;
  logic             take_pend;
  logic             store_pend;
  logic             pend_full_nxt;

  // Incoming frame is clamped and left-aligned so its first bit sits at the MSB.
  always_comb begin
    acc_len  = (int'(in_len) > WIDTH) ? LEN_W'(WIDTH) : in_len;
    acc_data = in_data << (WIDTH - int'(acc_len));
  end

  assign accept = in_valid && in_ready;
  assign acc_nz = accept && (acc_len != '0);

  always_comb begin
    load_pt = 1'b0;
    case (state)
      S_IDLE:  load_pt = 1'b1;
      S_SHIFT: load_pt = (bit_cnt == LEN_W'(1)) && (GAP == 0);
      S_GAP:   load_pt = (gap_cnt == '0);
      default: load_pt = 1'b1;
    endcase
    take_pend     = load_pt && pend_full;
    store_pend    = acc_nz && !(load_pt && !pend_full);
    pend_full_nxt = (pend_full && !take_pend) || store_pend;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      first_bit <= 1'b0;
      gap_cnt   <= '0;
      pend_data <= '0;
      pend_len  <= '0;
      pend_full <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        S_SHIFT: begin
          if (bit_cnt > LEN_W'(1)) begin
            shift_reg <= shift_reg << 1;
            bit_cnt   <= bit_cnt - 1'b1;
            first_bit <= 1'b0;
          end else if (GAP > 0) begin
            state   <= S_GAP;
            gap_cnt <= GAP_M1;
          end
        end
        S_GAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        end
        default: ;
      endcase

      // The pending frame always wins over a new arrival to keep order.
      if (load_pt) begin
        if (pend_full) begin
          shift_reg <= pend_data;
          bit_cnt   <= pend_len;
          first_bit <= 1'b1;
          state     <= S_SHIFT;
        end else if (acc_nz) begin
          shift_reg <= acc_data;
          bit_cnt   <= acc_len;
          first_bit <= 1'b1;
          state     <= S_SHIFT;
        end else begin
          state <= S_IDLE;
        end
      end

      if (store_pend) begin
        pend_data <= acc_data;
        pend_len  <= acc_len;
      end
      pend_full <= pend_full_nxt;
      in_ready  <= !pend_full_nxt;
    end
  end

  assign out_valid    = (state == S_SHIFT);
  assign sequence_out = out_valid && shift_reg[WIDTH-1];
  assign frame_start  = out_valid && first_bit;
  assign frame_done   = out_valid && (bit_cnt == LEN_W'(1));
  assign busy         = (state != S_IDLE) || pend_full;

  // KMP transition: longest pattern prefix that is a suffix of (matched prefix + new bit).
  function automatic logic [MS_W-1:0] next_match(input logic [MS_W-1:0] m, input logic b);
    int                 best;
    int                 j;
    logic               ok;
    logic               c;
    logic [PAT_LEN-1:0] tmp;
    best = 0;
    for (int k = 1; k <= PAT_LEN; k++) begin
      ok = (k <= int'(m) + 1);
      for (int i = 0; i < PAT_LEN; i++) begin
        if (ok && (i < k)) begin
          j = int'(m) + 1 - k + i;
          if (j == int'(m)) begin
            c = b;
          end else begin
            tmp = PATTERN >> (PAT_LEN - 1 - j);
            c   = tmp[0];
          end
          tmp = PATTERN >> (PAT_LEN - 1 - i);
          if (c != tmp[0]) ok = 1'b0;
        end
      end
      if (ok) best = k;
    end
    return MS_W'(best);
  endfunction

  assign mstate_nxt = next_match(mstate, sequence_out);

  always_ff @(posedge clock) begin
    if (reset) begin
      mstate  <= '0;
      hit_cnt <= '0;
    end else begin
      mstate <= mstate_nxt;
      if ((mstate_nxt == MS_W'(PAT_LEN)) && (hit_cnt != '1)) hit_cnt <= hit_cnt + 1'b1;
    end
  end

  assign pattern_hit   = (mstate == MS_W'(PAT_LEN));
  assign pattern_count = hit_cnt;

endmodule
